// File: rtl/morra_scoreboard_if.sv
// Bus between the morra game block's result outputs and the match scoreboard.
// Carries the game controls, the upstream results and the scoreboard counters.
interface morra_scoreboard_if;
  logic       START;
  logic [1:0] ROUND;
  logic [1:0] GAME;
  logic       MATCH_CLR;
  logic [4:0] P1_ROUNDS;
  logic [4:0] P2_ROUNDS;
  logic [4:0] TIES;
  logic [4:0] VOIDS;
  logic [2:0] P1_GAMES;
  logic [2:0] P2_GAMES;
  logic [3:0] DRAWS;
  logic       GAME_DONE;
  logic [1:0] MATCH;

  modport master (
    output START, ROUND, GAME, MATCH_CLR,
    input  P1_ROUNDS, P2_ROUNDS, TIES, VOIDS, P1_GAMES, P2_GAMES, DRAWS, GAME_DONE, MATCH
  );

  modport slave (
    input  START, ROUND, GAME, MATCH_CLR,
    output P1_ROUNDS, P2_ROUNDS, TIES, VOIDS, P1_GAMES, P2_GAMES, DRAWS, GAME_DONE, MATCH
  );
endinterface

// File: rtl/morra_scoreboard.sv
// Morra match scoreboard: tallies rounds per game and games per match,
// declaring a match winner once a player reaches GAMES_TO_WIN.
module morra_scoreboard #(
  parameter int unsigned GAMES_TO_WIN = 3
) (
  input logic                  clk,
  input logic                  RST_N,
  morra_scoreboard_if.slave    bus
);

  localparam int unsigned RW = 5;
  localparam int unsigned GW = 3;
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    SCORE      = 2'd2,
    MATCH_OVER = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] p1r_q, p1r_d, p2r_q, p2r_d, ties_q, ties_d, voids_q, voids_d;
  logic [GW-1:0] p1g_q, p1g_d, p2g_q, p2g_d;
  logic [DW-1:0] draws_q, draws_d;
  logic          done_q, done_d;
  logic [1:0]    match_q, match_d;

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v == '1) ? v : v + RW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q <= IDLE;
      p1r_q   <= '0;
      p2r_q   <= '0;
      ties_q  <= '0;
      voids_q <= '0;
      p1g_q   <= '0;
      p2g_q   <= '0;
      draws_q <= '0;
      done_q  <= 1'b0;
      match_q <= 2'b00;
    end else begin
      state_q <= state_d;
      p1r_q   <= p1r_d;
      p2r_q   <= p2r_d;
      ties_q  <= ties_d;
      voids_q <= voids_d;
      p1g_q   <= p1g_d;
      p2g_q   <= p2g_d;
      draws_q <= draws_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1r_d   = p1r_q;
    p2r_d   = p2r_q;
    ties_d  = ties_q;
    voids_d = voids_q;
    p1g_d   = p1g_q;
    p2g_d   = p2g_q;
    draws_d = draws_q;
    done_d  = 1'b0;
    match_d = match_q;

    if (bus.MATCH_CLR) begin
      state_d = IDLE;
      p1r_d   = '0;
      p2r_d   = '0;
      ties_d  = '0;
      voids_d = '0;
      p1g_d   = '0;
      p2g_d   = '0;
      draws_d = '0;
      match_d = 2'b00;
    end else if (state_q != MATCH_OVER && bus.START) begin
      // START (re)opens a game from any non-terminal state, trumping GAME
      state_d = PLAY;
      p1r_d   = '0;
      p2r_d   = '0;
      ties_d  = '0;
      voids_d = '0;
    end else if (state_q == PLAY) begin
      if (bus.GAME == 2'b00) begin
        unique case (bus.ROUND)
          2'b01:   p1r_d   = sat_inc(p1r_q);
          2'b10:   p2r_d   = sat_inc(p2r_q);
          2'b11:   ties_d  = sat_inc(ties_q);
          default: voids_d = sat_inc(voids_q);
        endcase
      end else begin
        done_d  = 1'b1;
        state_d = SCORE;
        unique case (bus.GAME)
          2'b01: begin
            p1g_d = p1g_q + GW'(1);
            if (p1g_d == GW'(GAMES_TO_WIN)) begin
              match_d = 2'b01;
              state_d = MATCH_OVER;
            end
          end
          2'b10: begin
            p2g_d = p2g_q + GW'(1);
            if (p2g_d == GW'(GAMES_TO_WIN)) begin
              match_d = 2'b10;
              state_d = MATCH_OVER;
            end
          end
          default: draws_d = (draws_q == '1) ? draws_q : draws_q + DW'(1);
        endcase
      end
    end
  end

  assign bus.P1_ROUNDS = p1r_q;
  assign bus.P2_ROUNDS = p2r_q;
  assign bus.TIES      = ties_q;
  assign bus.VOIDS     = voids_q;
  assign bus.P1_GAMES  = p1g_q;
  assign bus.P2_GAMES  = p2g_q;
  assign bus.DRAWS     = draws_q;
  assign bus.GAME_DONE = done_q;
  assign bus.MATCH     = match_q;

endmodule

// File: tb/tb_morra_scoreboard.sv
// Directed bench for morra_scoreboard with GAMES_TO_WIN = 3.
module tb_morra_scoreboard;
  logic clk;
  logic RST_N;
  int   checks;
  int   errors;

  morra_scoreboard_if bus ();

  morra_scoreboard #(.GAMES_TO_WIN(3)) dut (
    .clk  (clk),
    .RST_N(RST_N),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Order: p1r p2r ties voids p1g p2g draws done match
  task automatic chk_all(input string tag, input int p1r, input int p2r, input int ti,
                         input int vo, input int p1g, input int p2g, input int dr,
                         input int gd, input int mt);
    chk({tag, ".P1_ROUNDS"}, 8'(bus.P1_ROUNDS), 8'(p1r));
    chk({tag, ".P2_ROUNDS"}, 8'(bus.P2_ROUNDS), 8'(p2r));
    chk({tag, ".TIES"},      8'(bus.TIES),      8'(ti));
    chk({tag, ".VOIDS"},     8'(bus.VOIDS),     8'(vo));
    chk({tag, ".P1_GAMES"},  8'(bus.P1_GAMES),  8'(p1g));
    chk({tag, ".P2_GAMES"},  8'(bus.P2_GAMES),  8'(p2g));
    chk({tag, ".DRAWS"},     8'(bus.DRAWS),     8'(dr));
    chk({tag, ".GAME_DONE"}, 8'(bus.GAME_DONE), 8'(gd));
    chk({tag, ".MATCH"},     8'(bus.MATCH),     8'(mt));
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    RST_N = 1'b0;
    bus.START = 1'b0;
    bus.ROUND = 2'b00;
    bus.GAME = 2'b00;
    bus.MATCH_CLR = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Idle after reset release: rounds are not counted
    RST_N = 1'b1;
    bus.ROUND = 2'b01;
    tick();
    chk_all("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Game 1: rounds 01,10,11,00,01 then P1 wins
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.ROUND = 2'b01; tick();
    bus.ROUND = 2'b10; tick();
    bus.ROUND = 2'b11; tick();
    bus.ROUND = 2'b00; tick();
    bus.ROUND = 2'b01; tick();
    chk_all("g1_rounds", 2, 1, 1, 1, 0, 0, 0, 0, 0);
    bus.GAME = 2'b01;
    tick();
    chk_all("g1_done", 2, 1, 1, 1, 1, 0, 0, 1, 0);
    tick();
    chk_all("g1_score_hold", 2, 1, 1, 1, 1, 0, 0, 0, 0);

    // Game 2: P1 wins again
    bus.GAME = 2'b00;
    bus.START = 1'b1;
    tick();
    chk_all("g2_start", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    bus.START = 1'b0;
    bus.ROUND = 2'b01; tick();
    bus.GAME = 2'b01; tick();
    chk_all("g2_done", 1, 0, 0, 0, 2, 0, 0, 1, 0);

    // Game 3: P1 takes the match
    bus.GAME = 2'b00;
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.ROUND = 2'b10; tick();
    bus.GAME = 2'b01; tick();
    chk_all("g3_match", 0, 1, 0, 0, 3, 0, 0, 1, 1);
    bus.GAME = 2'b00;
    bus.ROUND = 2'b01;
    bus.START = 1'b1; tick();
    bus.START = 1'b0; tick();
    chk_all("match_over_hold", 0, 1, 0, 0, 3, 0, 0, 0, 1);

    // Clear with START held: everything zero, back to idle
    bus.MATCH_CLR = 1'b1;
    bus.START = 1'b1;
    tick();
    chk_all("clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.MATCH_CLR = 1'b0;
    bus.START = 1'b0;
    tick();
    chk_all("clr_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Void saturation over 40 rounds
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.ROUND = 2'b00;
    for (int i = 0; i < 40; i++) tick();
    chk_all("void_sat", 0, 0, 0, 31, 0, 0, 0, 0, 0);

    // P2 wins one game, then abort the next one after 4 rounds
    bus.GAME = 2'b10; tick();
    chk_all("p2_game", 0, 0, 0, 31, 0, 1, 0, 1, 0);
    bus.GAME = 2'b00;
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.ROUND = 2'b01; tick();
    bus.ROUND = 2'b01; tick();
    bus.ROUND = 2'b10; tick();
    bus.ROUND = 2'b11; tick();
    chk_all("abort_pre", 2, 1, 1, 0, 0, 1, 0, 0, 0);
    bus.START = 1'b1; tick();
    chk_all("abort", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // START together with GAME result: treated as START only
    bus.GAME = 2'b01; tick();
    chk_all("start_and_game", 0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Draw held 5 cycles: counted once, one pulse
    bus.START = 1'b0;
    bus.GAME = 2'b11;
    tick();
    chk_all("draw", 0, 0, 0, 0, 0, 1, 1, 1, 0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.GAME_DONE === 1'b1) pulses++;
    end
    chk("draw_extra_pulses", 8'(pulses), 8'd0);
    chk("draw_once", 8'(bus.DRAWS), 8'd1);
    bus.MATCH_CLR = 1'b1;
    bus.START = 1'b1;
    tick();
    chk_all("draw_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.MATCH_CLR = 1'b0;
    bus.START = 1'b0;
    bus.GAME = 2'b00;
    bus.ROUND = 2'b01;
    tick();
    chk_all("draw_clr_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-game with P2_ROUNDS=3, P2_GAMES=2
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.GAME = 2'b10; tick();
    bus.GAME = 2'b00;
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.GAME = 2'b10; tick();
    bus.GAME = 2'b00;
    bus.START = 1'b1; tick();
    bus.START = 1'b0;
    bus.ROUND = 2'b10;
    tick(); tick(); tick();
    chk_all("pre_reset", 0, 3, 0, 0, 0, 2, 0, 0, 0);
    RST_N = 1'b0;
    bus.GAME = 2'b10;
    tick();
    chk_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    tick();
    chk_all("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morra_scoreboard.md
MORRA_SCOREBOARD -- requirements
Module: morra_scoreboard

Interface
REQ-001 SHALL provide parameter GAMES_TO_WIN, default 3, games a player needs to take the match (legal range 1..7).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port START  input  1  same START driven into the upstream game block; starts/restarts a game.
REQ-005 SHALL provide port ROUND  input  2  upstream round result: 00 void, 01 P1 win, 10 P2 win, 11 tie.
REQ-006 SHALL provide port GAME  input  2  upstream game result, level: 00 in progress, 01 P1 win, 10 P2 win, 11 draw.
REQ-007 SHALL provide port MATCH_CLR  input  1  clears all match totals and returns to IDLE.
REQ-008 SHALL provide port P1_ROUNDS, P2_ROUNDS, TIES, VOIDS  output  5 each  per-game round counters.
REQ-009 SHALL provide port P1_GAMES, P2_GAMES  output  3 each  games won this match.
REQ-010 SHALL provide port DRAWS  output  4  drawn games this match.
REQ-011 SHALL provide port GAME_DONE  output  1  one-cycle pulse when a game result is recorded.
REQ-012 SHALL provide port MATCH  output  2  00 in progress, 01 P1 took match, 10 P2 took match; held until clear.

Function
REQ-013 SHALL implement states IDLE, PLAY, SCORE, MATCH_OVER; all outputs registered.
REQ-014 Priority each edge SHALL be: RST_N low > MATCH_CLR high > START high > normal operation.
REQ-015 IDLE: START=1 -> PLAY, per-game round counters cleared; otherwise hold.
REQ-016 PLAY, START=0, GAME=00: SHALL count ROUND each cycle: 01 P1_ROUNDS+1, 10 P2_ROUNDS+1, 11 TIES+1, 00 VOIDS+1 (one round per clock, no handshake).
REQ-017 Round counters SHALL saturate at 31, never wrap.
REQ-018 PLAY, START=0, GAME!=00: SHALL not count ROUND that cycle; SHALL increment P1_GAMES (01), P2_GAMES (10) or DRAWS (11, saturating at 15); SHALL assert GAME_DONE next cycle for exactly one cycle; go to SCORE.
REQ-019 Same edge as REQ-018: if updated P1_GAMES or P2_GAMES equals GAMES_TO_WIN, SHALL set MATCH to 01/10 and go to MATCH_OVER instead of SCORE.
REQ-020 SCORE: round counters SHALL hold last game's values; GAME level ignored (no double count); START=1 -> PLAY with round counters cleared, game totals kept.
REQ-021 START=1 in PLAY (abort mid-game) SHALL clear round counters, stay in PLAY, record no game, no GAME_DONE.
REQ-022 START=1 with GAME!=00 on the same edge SHALL be treated as START only (no game recorded).
REQ-023 MATCH_OVER: START SHALL be ignored; all outputs hold; only MATCH_CLR or reset leaves.
REQ-024 MATCH_CLR=1 in any state SHALL zero all counters, MATCH, GAME_DONE and go to IDLE; simultaneous START ignored that cycle.

Reset
REQ-025 RST_N=0 at an edge SHALL force IDLE and zero every output (counters, GAME_DONE=0, MATCH=00), regardless of other inputs.
REQ-026 Reset asserted mid-game SHALL discard the game in progress; no GAME_DONE on release.
REQ-027 After RST_N returns high, block SHALL wait in IDLE for START.

Verification
REQ-028 Reset, START 1 cycle, ROUND seq 01,10,11,00,01 with GAME=00, then GAME=01 -> P1_ROUNDS=2, P2_ROUNDS=1, TIES=1, VOIDS=1, P1_GAMES=1, GAME_DONE one cycle, state SCORE.
REQ-029 Three games P1 win, GAMES_TO_WIN=3 -> after third, MATCH=01, P1_GAMES=3; further START pulse changes nothing.
REQ-030 40 cycles of ROUND=00 in PLAY -> VOIDS=31 (saturated), other counters 0.
REQ-031 START during PLAY after 4 counted rounds -> all round counters 0 next cycle, games unchanged, GAME_DONE stays 0.
REQ-032 GAME=11 held 5 cycles after game end -> DRAWS=1 only, single GAME_DONE pulse; then MATCH_CLR with START high -> all zero, IDLE.
REQ-033 RST_N low one cycle mid-game with P2_ROUNDS=3, P2_GAMES=2 -> all outputs 0 next cycle, IDLE.
